// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with a multi-cycle multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide work on operand magnitudes.
// Signs are applied once the last iteration is done, so the most negative
// operand is simply the magnitude 2^(WIDTH-1) and cannot overflow.
module hilo_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hilowriteE,
    input  logic             hiloselE,
    input  logic             cancelE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stallE,
    output logic             doneE
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;      // product high half / partial remainder
    logic [W-1:0]   shf_q, shf_d;      // multiplier / dividend shifting into quotient
    logic [W-1:0]   mag_q, mag_d;      // multiplicand / divisor magnitude
    logic [1:0]     op_q, op_d;
    logic           sa_q, sa_d;        // raw sign bit of srcaE
    logic           sb_q, sb_d;        // raw sign bit of srcbE
    logic           dz_q, dz_d;        // division by zero, no result load
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           accept_s;
    logic           div_zero_s;
    logic [W-1:0]   a_mag_s, b_mag_s;
    logic [W:0]     msum_s;
    logic [W:0]     rshift_s;
    logic [W:0]     rtrial_s;
    logic [2*W-1:0] prod_s;
    logic           neg_res_s;
    logic [W-1:0]   res_hi_s, res_lo_s;

    assign accept_s   = (state_q == S_IDLE) && startE && !cancelE;
    assign div_zero_s = opE[1] && (srcbE == {W{1'b0}});
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign doneE      = done_q;

    // State register and all datapath flops, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= {W{1'b0}};
            shf_q   <= {W{1'b0}};
            mag_q   <= {W{1'b0}};
            op_q    <= 2'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shf_q   <= shf_d;
            mag_q   <= mag_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a zero divisor jumps straight to DONE, cancel always wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = div_zero_s ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cancelE) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'(CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall request: held while a request is being accepted or iterations run
    always_comb begin
        stallE = 1'b0;
        if (rst && (((state_q == S_IDLE) && startE) || (state_q == S_RUN))) begin
            stallE = 1'b1;
        end else begin
            stallE = 1'b0;
        end
    end

    // Operand magnitudes; unsigned ops (opE[0]=1) use the raw value
    always_comb begin
        a_mag_s = srcaE;
        b_mag_s = srcbE;
        if (!opE[0] && srcaE[W-1]) begin
            a_mag_s = {W{1'b0}} - srcaE;
        end else begin
            a_mag_s = srcaE;
        end
        if (!opE[0] && srcbE[W-1]) begin
            b_mag_s = {W{1'b0}} - srcbE;
        end else begin
            b_mag_s = srcbE;
        end
    end

    // One multiply or divide iteration per RUN cycle, operand latch on accept
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shf_d    = shf_q;
        mag_d    = mag_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        msum_s   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
        rshift_s = {acc_q, shf_q[W-1]};
        rtrial_s = rshift_s - {1'b0, mag_q};
        if (accept_s) begin
            cnt_d = 6'd0;
            acc_d = {W{1'b0}};
            shf_d = a_mag_s;
            mag_d = b_mag_s;
            op_d  = opE;
            sa_d  = srcaE[W-1];
            sb_d  = srcbE[W-1];
            dz_d  = div_zero_s;
        end else if ((state_q == S_RUN) && !cancelE) begin
            cnt_d = cnt_q + 6'd1;
            if (op_q[1]) begin
                if (!rtrial_s[W]) begin
                    acc_d = rtrial_s[W-1:0];
                    shf_d = {shf_q[W-2:0], 1'b1};
                end else begin
                    acc_d = rshift_s[W-1:0];
                    shf_d = {shf_q[W-2:0], 1'b0};
                end
            end else begin
                acc_d = msum_s[W:1];
                shf_d = {msum_s[0], shf_q[W-1:1]};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Final sign fix-up: product/quotient negated on sign mismatch, remainder follows dividend
    always_comb begin
        neg_res_s = !op_q[0] && (sa_q ^ sb_q);
        prod_s    = {acc_q, shf_q};
        res_hi_s  = acc_q;
        res_lo_s  = shf_q;
        if (op_q[1]) begin
            res_lo_s = neg_res_s ? ({W{1'b0}} - shf_q) : shf_q;
            res_hi_s = (!op_q[0] && sa_q) ? ({W{1'b0}} - acc_q) : acc_q;
        end else begin
            if (neg_res_s) begin
                prod_s = {(2*W){1'b0}} - {acc_q, shf_q};
            end else begin
                prod_s = {acc_q, shf_q};
            end
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
        end
    end

    // HI/LO update: direct writes in IDLE, result load and done pulse leaving DONE
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hilowriteE) begin
                    if (hiloselE) begin
                        hi_d = srcaE;
                    end else begin
                        lo_d = srcaE;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            S_DONE: begin
                if (!cancelE) begin
                    done_d = 1'b1;
                    if (!dz_q) begin
                        hi_d = res_hi_s;
                        lo_d = res_lo_s;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            default: done_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: a timing/arithmetic reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_hilo_muldiv;

    localparam int CYC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'd0;
    logic [31:0] srcaE = 32'd0;
    logic [31:0] srcbE = 32'd0;
    logic        hilowriteE = 1'b0;
    logic        hiloselE = 1'b0;
    logic        cancelE = 1'b0;
    logic [31:0] hi, lo;
    logic        stallE, doneE;

    int checks = 0;
    int errors = 0;

    hilo_muldiv #(.WIDTH(32), .CYCLES(CYC)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE),
        .srcbE(srcbE), .hilowriteE(hilowriteE), .hiloselE(hiloselE),
        .cancelE(cancelE), .hi(hi), .lo(lo), .stallE(stallE), .doneE(doneE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; rh = up[63:32]; rl = up[31:0]; end
            2'd2: begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            default: begin rl = a / b; rh = a % b; end
        endcase
    endfunction

    // Model state: left = edges until the result load (0 = idle, 1 = done phase)
    int          left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          p_dz = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (left == 0) begin
                if (hilowriteE) begin
                    if (hiloselE) m_hi = srcaE;
                    else          m_lo = srcaE;
                end
                if (startE && !cancelE) begin
                    p_dz = opE[1] && (srcbE == 32'd0);
                    if (!p_dz) ref_op(opE, srcaE, srcbE, p_hi, p_lo);
                    left = p_dz ? 1 : CYC + 1;
                end
            end else if (cancelE) begin
                left = 0;
            end else begin
                left--;
                if (left == 0) begin
                    if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
                    m_done = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = rst && (((left == 0) && startE) || (left > 1));
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
        chk("doneE", {63'd0, doneE}, {63'd0, m_done});
        chk("stallE", {63'd0, stallE}, {63'd0, exp_stall});
    end

    task automatic step(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic hs, input logic c);
        @(posedge clk);
        #2;
        startE = s; opE = op; srcaE = a; srcbE = b;
        hilowriteE = hw; hiloselE = hs; cancelE = c;
        @(negedge clk);
    endtask

    task automatic idle_run(input int n, output int stall_n, output int done_n, output int done_at);
        stall_n = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= n; i++) begin
            step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            if (stallE) stall_n++;
            if (doneE) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 20));
            4: v = 32'd0 - 32'($urandom_range(1, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        int sn, dn, da, st0;
        #12;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_stall", {63'd0, stallE}, 64'd0);
        chk("rst_done", {63'd0, doneE}, 64'd0);
        @(posedge clk); #2; rst = 1'b1;

        // MULTU all-ones squared
        step(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        st0 = int'(stallE);
        idle_run(40, sn, dn, da);
        chk("multu_stall_cycles", 64'(st0 + sn), 64'd33);
        chk("multu_done_count", 64'(dn), 64'd1);
        chk("multu_done_edge", 64'(da), 64'd34);
        chk("multu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);

        // MULT -3 x 7
        step(1'b1, 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
        idle_run(36, sn, dn, da);
        chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

        // DIV -7 / 2
        step(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        idle_run(36, sn, dn, da);
        chk("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

        // DIVU by zero keeps HI/LO
        step(1'b0, 2'd0, 32'h11, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd0, 32'h22, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
        st0 = int'(stallE);
        idle_run(10, sn, dn, da);
        chk("div0_stall_cycles", 64'(st0 + sn), 64'd1);
        chk("div0_done_edge", 64'(da), 64'd2);
        chk("div0_done_count", 64'(dn), 64'd1);
        chk("div0_hi", {32'd0, hi}, 64'h11);
        chk("div0_lo", {32'd0, lo}, 64'h22);

        // Most negative / -1, then MTHI
        step(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle_run(36, sn, dn, da);
        chk("minneg_done_count", 64'(dn), 64'd1);
        chk("minneg_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        chk("minneg_hi", {32'd0, hi}, 64'd0);
        step(1'b0, 2'd0, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
        idle_run(1, sn, dn, da);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);

        // Cancel mid-RUN, then a fresh start is accepted
        step(1'b1, 2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        idle_run(9, sn, dn, da);
        step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle_run(40, sn, dn, da);
        chk("cancel_done_count", 64'(dn), 64'd0);
        chk("cancel_hi", {32'd0, hi}, 64'h1234);
        chk("cancel_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        step(1'b1, 2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        idle_run(36, sn, dn, da);
        chk("after_cancel_lo", {32'd0, lo}, 64'd25);
        chk("after_cancel_hi", {32'd0, hi}, 64'd0);

        // Reset between edges in the middle of RUN
        step(1'b1, 2'd0, 32'h1234_5678, 32'hFFFF_0001, 1'b0, 1'b0, 1'b0);
        idle_run(5, sn, dn, da);
        @(posedge clk); #3; rst = 1'b0; #1;
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_stall", {63'd0, stallE}, 64'd0);
        chk("midrst_done", {63'd0, doneE}, 64'd0);
        @(posedge clk); #2; rst = 1'b1;
        idle_run(40, sn, dn, da);
        chk("midrst_no_done", 64'(dn), 64'd0);
        step(1'b1, 2'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        idle_run(36, sn, dn, da);
        chk("post_rst_lo", {32'd0, lo}, 64'd12);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), pick(), pick(),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
        end
        idle_run(40, sn, dn, da);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
